bus_cycle_ctrl: RTL and testbench

- Parametrised 68008 bus-cycle controller that replaces the glue's fixed combinational decode and DTACK.
- Decodes NUM_REGIONS base/mask windows with per-region wait states and generates registered chip selects.
- Holds DTACK_n until AS_n is released, raises BERR_n on a watchdog timeout for unmapped accesses, and owns the boot-time ROM overlay.
- Sits between the CPU bus strobes and the memory/peripheral selects. Interrupt-acknowledge cycles are left to the interrupt logic.

---
 rtl/bus_cycle_if.sv | 25 ++
 rtl/bus_cycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_if.sv
// CPU-side bus bundle between the 68008 strobes and the bus-cycle controller.
// The controller consumes the slave modport; the CPU or a bench drives the master side.
interface bus_cycle_if #(
    parameter int ADDR_W      = 22,
    parameter int NUM_REGIONS = 4
);
    logic [ADDR_W-1:0]      ADDR;
    logic                   AS_n;
    logic                   DS_n;
    logic [2:0]             FC;
    logic [NUM_REGIONS-1:0] SEL_n;
    logic                   DTACK_n;
    logic                   BERR_n;
    logic                   BOOT;

    modport master (
        output ADDR, AS_n, DS_n, FC,
        input  SEL_n, DTACK_n, BERR_n, BOOT
    );

    modport slave (
        input  ADDR, AS_n, DS_n, FC,
        output SEL_n, DTACK_n, BERR_n, BOOT
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 68008 bus-cycle controller: base/mask region decode with per-region wait states,
// registered selects, DTACK/BERR generation and the boot-time ROM overlay.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no cycle in progress, all outputs inactive
// S_WAIT    | region selected, counting down its wait states
// S_ACK     | DTACK asserted, holding until AS_n is released
// S_TIMEOUT | unmapped access, watchdog counting towards BERR
// S_BERR    | BERR asserted, holding until AS_n is released
module bus_cycle_ctrl #(
    parameter int NUM_REGIONS  = 4,
    parameter int ADDR_W       = 22,
    parameter int WS_W         = 4,
    parameter int BERR_TIMEOUT = 64,
    parameter int BOOT_REGION  = 1,
    parameter int BOOT_CYCLES  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE,
    input  logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK,
    input  logic [NUM_REGIONS*WS_W-1:0]   REGION_WS,
    bus_cycle_if.slave                    bus
);
    localparam int TO_W   = $clog2(BERR_TIMEOUT + 1);
    localparam int BC_W   = $clog2(BOOT_CYCLES + 1);
    localparam int RIDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_TIMEOUT,
        S_BERR
    } state_t;

    state_t                 state_q, state_d;
    logic [RIDX_W-1:0]      region_q, region_d;
    logic [WS_W-1:0]        wait_q, wait_d;
    logic [TO_W-1:0]        to_q, to_d;
    logic [BC_W-1:0]        boot_cnt_q, boot_cnt_d;
    logic                   boot_q, boot_d;
    logic [NUM_REGIONS-1:0] sel_n_q, sel_n_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   berr_n_q, berr_n_d;

    logic                   start;
    logic                   hit;
    logic [RIDX_W-1:0]      hit_idx;
    logic [WS_W-1:0]        hit_ws;
    logic                   done;

    assign start = !bus.AS_n && !bus.DS_n && (bus.FC != 3'b111);

    // Descending scan so the lowest hitting index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if ((bus.ADDR & REGION_MASK[r*ADDR_W +: ADDR_W]) ==
                (REGION_BASE[r*ADDR_W +: ADDR_W] & REGION_MASK[r*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = RIDX_W'(r);
            end
        end
        if (!boot_q) begin
            hit     = 1'b1;
            hit_idx = RIDX_W'(BOOT_REGION);
        end
        hit_ws = REGION_WS[hit_idx*WS_W +: WS_W];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            region_q   <= '0;
            wait_q     <= '0;
            to_q       <= '0;
            boot_cnt_q <= '0;
            boot_q     <= 1'b0;
            sel_n_q    <= '1;
            dtack_n_q  <= 1'b1;
            berr_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            wait_q     <= wait_d;
            to_q       <= to_d;
            boot_cnt_q <= boot_cnt_d;
            boot_q     <= boot_d;
            sel_n_q    <= sel_n_d;
            dtack_n_q  <= dtack_n_d;
            berr_n_q   <= berr_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        wait_d     = wait_q;
        to_d       = to_q;
        boot_cnt_d = boot_cnt_q;
        boot_d     = boot_q;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (hit) begin
                        state_d  = S_WAIT;
                        region_d = hit_idx;
                        wait_d   = hit_ws;
                    end else begin
                        state_d = S_TIMEOUT;
                        to_d    = TO_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // A zero count means DTACK is already on the bus, so a release here completes the cycle.
                if (wait_q == '0) begin
                    if (bus.AS_n) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = S_ACK;
                    end
                end else if (bus.AS_n) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q - WS_W'(1);
                end
            end
            S_ACK: begin
                if (bus.AS_n) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            S_TIMEOUT: begin
                if (bus.AS_n) begin
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (to_q == TO_W'(BERR_TIMEOUT - 1)) begin
                        state_d = S_BERR;
                    end
                end
            end
            S_BERR: begin
                if (bus.AS_n) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (done && !boot_q) begin
            boot_cnt_d = boot_cnt_q + BC_W'(1);
            if (boot_cnt_q == BC_W'(BOOT_CYCLES - 1)) begin
                boot_d = 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so the pins never glitch.
    always_comb begin
        sel_n_d   = '1;
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        if (state_d == S_WAIT || state_d == S_ACK) begin
            sel_n_d[region_d] = 1'b0;
        end
        if ((state_d == S_WAIT && wait_d == '0) || state_d == S_ACK) begin
            dtack_n_d = 1'b0;
        end
        if (state_d == S_BERR) begin
            berr_n_d = 1'b0;
        end
    end

    assign bus.SEL_n   = sel_n_q;
    assign bus.DTACK_n = dtack_n_q;
    assign bus.BERR_n  = berr_n_q;
    assign bus.BOOT    = boot_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: a cycle-timing model checked every cycle plus directed literal checks.
module tb_bus_cycle_ctrl;
    localparam int NR   = 4;
    localparam int AW   = 22;
    localparam int WW   = 4;
    localparam int BT   = 64;
    localparam int BREG = 1;
    localparam int BCYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] base_cfg [NR];
    logic [AW-1:0] mask_cfg [NR];
    logic [WW-1:0] ws_cfg   [NR];
    logic [NR*AW-1:0] region_base;
    logic [NR*AW-1:0] region_mask;
    logic [NR*WW-1:0] region_ws;

    assign region_base = {base_cfg[3], base_cfg[2], base_cfg[1], base_cfg[0]};
    assign region_mask = {mask_cfg[3], mask_cfg[2], mask_cfg[1], mask_cfg[0]};
    assign region_ws   = {ws_cfg[3], ws_cfg[2], ws_cfg[1], ws_cfg[0]};

    bus_cycle_if #(.ADDR_W(AW), .NUM_REGIONS(NR)) bus ();

    bus_cycle_ctrl #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .WS_W(WW),
        .BERR_TIMEOUT(BT), .BOOT_REGION(BREG), .BOOT_CYCLES(BCYC)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .REGION_BASE(region_base),
        .REGION_MASK(region_mask),
        .REGION_WS(region_ws),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: a bus cycle is an interval of edges; outputs follow from elapsed edges since the start.
    int       cyc = 0;
    bit       m_valid = 0;
    bit       m_busy = 0;
    bit       m_mapped = 0;
    bit       m_boot = 0;
    bit       m_done = 0;
    int       m_start = 0;
    int       m_reg = 0;
    int       m_ws = 0;
    int       m_ncomp = 0;
    logic [NR-1:0] e_sel = '1;
    logic     e_dtack = 1'b1;
    logic     e_berr = 1'b1;
    logic     e_boot = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid = 1;
            m_busy  = 0;
            m_boot  = 0;
            m_ncomp = 0;
        end else if (!m_busy) begin
            if (!bus.AS_n && !bus.DS_n && bus.FC != 3'b111) begin
                m_busy   = 1;
                m_start  = cyc;
                m_mapped = 0;
                if (!m_boot) begin
                    m_mapped = 1;
                    m_reg    = BREG;
                end else begin
                    for (int r = NR - 1; r >= 0; r--) begin
                        if ((bus.ADDR & mask_cfg[r]) == (base_cfg[r] & mask_cfg[r])) begin
                            m_mapped = 1;
                            m_reg    = r;
                        end
                    end
                end
                m_ws = int'(ws_cfg[m_reg]);
            end
        end else if (bus.AS_n) begin
            if (m_mapped) m_done = (cyc - 1 >= m_start + m_ws);
            else          m_done = (cyc - 1 >= m_start + BT - 1);
            m_busy = 0;
            if (m_done && !m_boot) begin
                m_ncomp++;
                if (m_ncomp == BCYC) m_boot = 1;
            end
        end
        e_sel   = '1;
        e_dtack = 1'b1;
        e_berr  = 1'b1;
        if (m_busy) begin
            if (m_mapped) begin
                e_sel[m_reg] = 1'b0;
                e_dtack = !(cyc >= m_start + m_ws);
            end else begin
                e_berr = !(cyc >= m_start + BT - 1);
            end
        end
        e_boot = m_boot;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests++;
            if (bus.SEL_n !== e_sel || bus.DTACK_n !== e_dtack ||
                bus.BERR_n !== e_berr || bus.BOOT !== e_boot) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d got sel=%b dtack=%b berr=%b boot=%b exp sel=%b dtack=%b berr=%b boot=%b",
                         cyc, bus.SEL_n, bus.DTACK_n, bus.BERR_n, bus.BOOT,
                         e_sel, e_dtack, e_berr, e_boot);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.AS_n = 1'b1;
        bus.DS_n = 1'b1;
        bus.FC   = 3'b101;
    endtask

    task automatic begin_cycle(input logic [AW-1:0] addr, input logic [2:0] fc);
        bus.ADDR = addr;
        bus.FC   = fc;
        bus.AS_n = 1'b0;
        bus.DS_n = 1'b0;
    endtask

    // One complete read, waiting a bounded time for DTACK, then release and one idle cycle.
    task automatic read_cycle(input string name, input logic [AW-1:0] addr, input logic [NR-1:0] exp_sel);
        begin_cycle(addr, 3'b101);
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.DTACK_n == 1'b0) break;
        end
        chk({name, "_dtack"}, 32'(bus.DTACK_n), 32'h0);
        chk({name, "_sel"}, 32'(bus.SEL_n), 32'(exp_sel));
        step();
        bus_idle();
        step();
        chk({name, "_release"}, 32'({bus.SEL_n, bus.DTACK_n}), 32'h1F);
        step();
    endtask

    initial begin
        base_cfg[0] = 22'h000000; mask_cfg[0] = 22'h300000; ws_cfg[0] = 4'd0;
        base_cfg[1] = 22'h100000; mask_cfg[1] = 22'h300000; ws_cfg[1] = 4'd1;
        base_cfg[2] = 22'h3FC000; mask_cfg[2] = 22'h3FE000; ws_cfg[2] = 4'd3;
        base_cfg[3] = 22'h000000; mask_cfg[3] = 22'h3F0000; ws_cfg[3] = 4'd2;
        bus.ADDR = '0;
        bus_idle();
        rst = 1'b1;
        step();
        step();
        chk("reset_sel", 32'(bus.SEL_n), 32'hF);
        chk("reset_dtack_berr", 32'({bus.DTACK_n, bus.BERR_n}), 32'h3);
        chk("reset_boot", 32'(bus.BOOT), 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < BCYC; i++) begin
            chk("boot_low_before", 32'(bus.BOOT), 32'h0);
            read_cycle("boot_read", 22'h000010, 4'b1101);
        end
        chk("boot_high_after", 32'(bus.BOOT), 32'h1);

        read_cycle("post_boot_overlap", 22'h000010, 4'b1110);

        begin_cycle(22'h000020, 3'b101);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("zws_sel", 32'(bus.SEL_n), 32'hE);
            chk("zws_dtack", 32'(bus.DTACK_n), 32'h0);
        end
        bus_idle();
        step();
        chk("zws_release", 32'({bus.SEL_n, bus.DTACK_n}), 32'h1F);
        step();

        begin_cycle(22'h3FC001, 3'b101);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("ws3_sel", 32'(bus.SEL_n), 32'hB);
            chk("ws3_dtack", 32'(bus.DTACK_n), (k == 4) ? 32'h0 : 32'h1);
        end
        step();
        bus_idle();
        step();
        chk("ws3_release", 32'({bus.SEL_n, bus.DTACK_n}), 32'h1F);
        step();

        begin_cycle(22'h200000, 3'b101);
        for (int k = 1; k <= 63; k++) begin
            step();
            if (k == 1) chk("unmapped_nosel", 32'({bus.SEL_n, bus.DTACK_n}), 32'h1F);
        end
        chk("berr_before", 32'(bus.BERR_n), 32'h1);
        step();
        chk("berr_at_timeout", 32'(bus.BERR_n), 32'h0);
        chk("berr_no_dtack", 32'(bus.DTACK_n), 32'h1);
        step();
        step();
        chk("berr_held", 32'(bus.BERR_n), 32'h0);
        bus_idle();
        step();
        chk("berr_release", 32'(bus.BERR_n), 32'h1);
        step();

        begin_cycle(22'h000010, 3'b111);
        repeat (200) step();
        chk("iack_quiet", 32'({bus.SEL_n, bus.DTACK_n, bus.BERR_n}), 32'h3F);
        bus_idle();
        step();

        begin_cycle(22'h3FC001, 3'b101);
        step();
        chk("abort_sel", 32'(bus.SEL_n), 32'hB);
        bus_idle();
        step();
        chk("abort_release", 32'({bus.SEL_n, bus.DTACK_n}), 32'h1F);
        step();

        ws_cfg[2] = 4'd7;
        step();
        begin_cycle(22'h3FC001, 3'b101);
        step();
        step();
        step();
        chk("rst_wait_sel", 32'(bus.SEL_n), 32'hB);
        rst = 1'b1;
        step();
        chk("rst_mid_sel", 32'(bus.SEL_n), 32'hF);
        chk("rst_mid_dtack", 32'(bus.DTACK_n), 32'h1);
        chk("rst_mid_boot", 32'(bus.BOOT), 32'h0);
        rst = 1'b0;
        bus_idle();
        step();
        read_cycle("rearm_overlay", 22'h3FC001, 4'b1101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
